// File: rtl/toggle_monitor.sv
// Measures the half-period of an asynchronous square wave and tracks lock
// against an expected half-period, with sticky error on loss of lock.
module toggle_monitor #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TOL   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             toggle_in,
  input  logic             en,
  input  logic [CNT_W-1:0] exp_half,
  input  logic             clr_err,
  output logic             edge_pulse,
  output logic             period_valid,
  output logic [CNT_W-1:0] half_period,
  output logic [CNT_W-1:0] toggle_count,
  output logic [1:0]       state,
  output logic             locked,
  output logic             timeout,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ACQUIRE = 2'b01,
    S_LOCKED  = 2'b10,
    S_LOST    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] HMAX = '1;

  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_hcnt;
  logic [1:0]       r_mcnt;
  state_t           r_state;
  logic [CNT_W-1:0] r_half_period;
  logic [CNT_W-1:0] r_toggle_count;
  logic             r_edge_pulse, r_period_valid, r_locked, r_timeout, r_err;

  logic             w_edge, w_sat, w_match, w_pv, w_err_set;
  logic [CNT_W:0]   w_hp_new, w_exp_ext, w_diff;
  logic [CNT_W-1:0] w_hp_sat;
  state_t           w_state_nxt;
  logic [1:0]       w_mcnt_nxt;

  assign w_edge    = en & (r_s2 ^ r_s3);
  assign w_hp_new  = {1'b0, r_hcnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_exp_ext = {1'b0, exp_half};
  assign w_diff    = (w_hp_new >= w_exp_ext) ? (w_hp_new - w_exp_ext)
                                             : (w_exp_ext - w_hp_new);
  assign w_match   = (w_diff <= (CNT_W+1)'(TOL));
  assign w_hp_sat  = w_hp_new[CNT_W] ? HMAX : w_hp_new[CNT_W-1:0];
  // An edge arriving on the saturation cycle takes precedence over timeout.
  assign w_sat     = en && !w_edge && (r_hcnt == HMAX) && (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_mcnt_nxt  = r_mcnt;
    w_pv        = 1'b0;
    w_err_set   = 1'b0;
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_mcnt_nxt  = 2'd0;
    end else if (w_sat) begin
      w_state_nxt = S_IDLE;
      w_mcnt_nxt  = 2'd0;
      w_err_set   = (r_state == S_LOCKED);
    end else if (w_edge) begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ACQUIRE;
          w_mcnt_nxt  = 2'd0;
        end
        S_ACQUIRE: begin
          w_pv = 1'b1;
          if (w_match) begin
            w_mcnt_nxt = r_mcnt + 2'd1;
            if (r_mcnt == 2'd1) w_state_nxt = S_LOCKED;
          end else begin
            w_mcnt_nxt = 2'd0;
          end
        end
        S_LOCKED: begin
          w_pv = 1'b1;
          if (!w_match) begin
            w_state_nxt = S_LOST;
            w_mcnt_nxt  = 2'd0;
            w_err_set   = 1'b1;
          end
        end
        S_LOST: begin
          w_pv = 1'b1;
          if (w_match) begin
            w_state_nxt = S_ACQUIRE;
            w_mcnt_nxt  = 2'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1           <= 1'b0;
      r_s2           <= 1'b0;
      r_s3           <= 1'b0;
      r_hcnt         <= '0;
      r_mcnt         <= 2'd0;
      r_state        <= S_IDLE;
      r_half_period  <= '0;
      r_toggle_count <= '0;
      r_edge_pulse   <= 1'b0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_timeout      <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_s1 <= toggle_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      if (!en || w_edge)     r_hcnt <= '0;
      else if (r_hcnt != HMAX) r_hcnt <= r_hcnt + 1'b1;

      if (w_edge) r_half_period <= w_hp_sat;

      if (!en)         r_toggle_count <= '0;
      else if (w_edge) r_toggle_count <= r_toggle_count + 1'b1;

      r_state        <= w_state_nxt;
      r_mcnt         <= w_mcnt_nxt;
      r_locked       <= (w_state_nxt == S_LOCKED);
      r_edge_pulse   <= w_edge;
      r_period_valid <= w_pv;
      r_timeout      <= w_sat;

      if (w_err_set)    r_err <= 1'b1;
      else if (clr_err) r_err <= 1'b0;
    end
  end

  assign edge_pulse   = r_edge_pulse;
  assign period_valid = r_period_valid;
  assign half_period  = r_half_period;
  assign toggle_count = r_toggle_count;
  assign state        = r_state;
  assign locked       = r_locked;
  assign timeout      = r_timeout;
  assign err          = r_err;

endmodule

// File: tb/tb_toggle_monitor.sv
// Directed bench for toggle_monitor at CNT_W=4, TOL=1, exp_half=5.
module tb_toggle_monitor;

  logic       clk;
  logic       reset;
  logic       toggle_in;
  logic       en;
  logic [3:0] exp_half;
  logic       clr_err;
  logic       edge_pulse, period_valid, locked, timeout, err;
  logic [3:0] half_period, toggle_count;
  logic [1:0] state;

  int unsigned vectors;
  int unsigned miscompares;

  localparam logic [1:0] ST_IDLE = 2'b00, ST_ACQ = 2'b01, ST_LOCK = 2'b10, ST_LOST = 2'b11;

  toggle_monitor #(.CNT_W(4), .TOL(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .toggle_in    (toggle_in),
    .en           (en),
    .exp_half     (exp_half),
    .clr_err      (clr_err),
    .edge_pulse   (edge_pulse),
    .period_valid (period_valid),
    .half_period  (half_period),
    .toggle_count (toggle_count),
    .state        (state),
    .locked       (locked),
    .timeout      (timeout),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Toggle the input, check the outputs of that edge three clocks later,
  // then check the pulses dropped. Consumes four clocks.
  task automatic half(input string tag, input logic [1:0] st, input logic pv,
                      input logic [3:0] hp, input logic [3:0] cnt, input logic er,
                      input bit clr);
    toggle_in = ~toggle_in;
    repeat (2) @(negedge clk);
    if (clr) clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk({tag, ".edge_pulse"}, edge_pulse, 1);
    chk({tag, ".period_valid"}, period_valid, pv);
    chk({tag, ".state"}, state, st);
    chk({tag, ".locked"}, locked, (st == ST_LOCK));
    chk({tag, ".err"}, err, er);
    chk({tag, ".toggle_count"}, toggle_count, cnt);
    chk({tag, ".timeout"}, timeout, 0);
    if (pv) chk({tag, ".half_period"}, half_period, hp);
    @(negedge clk);
    chk({tag, ".edge_pulse_low"}, edge_pulse, 0);
    chk({tag, ".period_valid_low"}, period_valid, 0);
  endtask

  task automatic clr_pulse(input string tag);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk({tag, ".err_cleared"}, err, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".state"}, state, ST_IDLE);
    chk({tag, ".locked"}, locked, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".half_period"}, half_period, 0);
    chk({tag, ".toggle_count"}, toggle_count, 0);
    chk({tag, ".edge_pulse"}, edge_pulse, 0);
    chk({tag, ".period_valid"}, period_valid, 0);
    chk({tag, ".timeout"}, timeout, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    en          = 1'b0;
    toggle_in   = 1'b0;
    clr_err     = 1'b0;
    exp_half    = 4'd5;
    repeat (2) @(negedge clk);
    chk_reset("por");
    reset = 1'b0;
    en    = 1'b1;
    idle(3);

    // Steady 5-clock halves: lock after the third edge.
    half("E1", ST_ACQ,  0, 0, 1, 0, 0); idle(1);
    half("E2", ST_ACQ,  1, 5, 2, 0, 0); idle(1);
    half("E3", ST_LOCK, 1, 5, 3, 0, 0); idle(1);
    half("E4", ST_LOCK, 1, 5, 4, 0, 0); idle(5);
    // One 9-clock half loses lock, then two good halves reacquire.
    half("E5", ST_LOST, 1, 9, 5, 1, 0); idle(1);
    half("E6", ST_ACQ,  1, 5, 6, 1, 0); idle(1);
    half("E7", ST_LOCK, 1, 5, 7, 1, 0);
    clr_pulse("E7clr");
    chk("E7clr.state", state, ST_LOCK);
    idle(4);
    // Mismatch while LOCKED with clr_err high on the same cycle.
    half("E8", ST_LOST, 1, 9, 8, 1, 1); idle(1);
    half("E9", ST_ACQ,  1, 5, 9, 1, 0); idle(1);
    half("E10", ST_LOCK, 1, 5, 10, 1, 0);
    clr_pulse("E10clr");
    // Toggle stops: hcnt reaches 15 sixteen clocks after the last detect.
    idle(13);
    chk("to_pre.timeout", timeout, 0);
    chk("to_pre.state", state, ST_LOCK);
    @(negedge clk);
    chk("to.timeout", timeout, 1);
    chk("to.state", state, ST_IDLE);
    chk("to.locked", locked, 0);
    chk("to.err", err, 1);
    chk("to.toggle_count", toggle_count, 10);
    chk("to.period_valid", period_valid, 0);
    @(negedge clk);
    chk("to_post.timeout", timeout, 0);
    chk("to_post.state", state, ST_IDLE);

    // Halves 4, 6, 7 against exp_half=5: match, match, mismatch.
    half("F1", ST_ACQ,  0, 0, 11, 1, 0);
    half("F2", ST_ACQ,  1, 4, 12, 1, 0); idle(2);
    half("F3", ST_LOCK, 1, 6, 13, 1, 0);
    clr_pulse("F3clr");
    idle(2);
    half("F4", ST_LOST, 1, 7, 14, 1, 0); idle(5);
    half("F5", ST_LOST, 1, 9, 15, 1, 0); idle(5);
    half("F6", ST_LOST, 1, 9, 0, 1, 0);  idle(2);

    // Reset in the middle of an interval.
    reset = 1'b1;
    #1;
    chk_reset("rst_mid");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(3);
    half("G1", ST_ACQ,  0, 0, 1, 0, 0); idle(1);
    half("G2", ST_ACQ,  1, 5, 2, 0, 0); idle(1);
    half("G3", ST_LOCK, 1, 5, 3, 0, 0); idle(1);
    half("G4", ST_LOCK, 1, 5, 4, 0, 0); idle(1);

    // Reset during a LOCKED run.
    reset = 1'b1;
    #1;
    chk_reset("rst_lock");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(3);
    half("H1", ST_ACQ, 0, 0, 1, 0, 0); idle(1);
    half("H2", ST_ACQ, 1, 5, 2, 0, 0);

    // Disabled: edges ignored, counters held at zero, no stale edge on re-enable.
    en = 1'b0;
    @(negedge clk);
    chk("dis.state", state, ST_IDLE);
    chk("dis.toggle_count", toggle_count, 0);
    toggle_in = ~toggle_in;
    repeat (3) @(negedge clk);
    chk("dis.edge_pulse", edge_pulse, 0);
    chk("dis.period_valid", period_valid, 0);
    chk("dis.state2", state, ST_IDLE);
    idle(2);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reen.edge_pulse", edge_pulse, 0);
    end
    chk("reen.state", state, ST_IDLE);
    chk("reen.toggle_count", toggle_count, 0);
    half("H3", ST_ACQ, 0, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/toggle_monitor.md
TOGGLE_MONITOR -- requirements
Module: toggle_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  CNT_W  16  width of all cycle/edge counters
  TOL    1   allowed |half_period - exp_half| for a match, in clocks
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk           in   1      single system clock, rising edge
  reset         in   1      asynchronous, active-high reset
  toggle_in     in   1      asynchronous square wave from the upstream toggle generator
  en            in   1      monitor enable
  exp_half      in   CNT_W  expected half-period, in clk cycles
  clr_err       in   1      clears sticky err
  edge_pulse    out  1      one-cycle pulse per detected toggle_in edge
  period_valid  out  1      one-cycle pulse; half_period updated
  half_period   out  CNT_W  last measured half-period, in clocks
  toggle_count  out  CNT_W  edges seen, wraps
  state         out  2      00 IDLE, 01 ACQUIRE, 10 LOCKED, 11 LOST
  locked        out  1      high iff state == LOCKED
  timeout       out  1      one-cycle pulse on half-period counter saturation
  err           out  1      sticky: lock lost or timeout while LOCKED
REQ-003 The block SHALL use one clock (clk) and an asynchronous, active-high reset (reset).

Function
REQ-004 toggle_in SHALL pass through a 2-flop synchronizer (s1, s2) plus history flop s3; an edge is detected in the cycle where s2 != s3.
REQ-005 edge_pulse SHALL be registered: high for exactly one cycle, starting 3 clk edges after the first edge that samples a new toggle_in value.
REQ-006 hcnt SHALL increment each cycle, saturating at 2^CNT_W-1; on a detect cycle: half_period <= hcnt+1 and hcnt <= 0 (toggle every N clocks -> half_period = N).
REQ-007 toggle_count SHALL increment on every detected edge while en=1 and SHALL wrap from 2^CNT_W-1 to 0.
REQ-008 Match: |half_period_new - exp_half| <= TOL, computed at CNT_W+1 bits with no wrap.
REQ-009 FSM transitions SHALL be evaluated only on detect cycles (except REQ-011):
  IDLE -> ACQUIRE on first edge; no period_valid, since the first interval is undefined.
  ACQUIRE: period_valid on each edge; a match increments mcnt; a mismatch clears mcnt; the 2nd consecutive match -> LOCKED.
  LOCKED: match stays; mismatch -> LOST and err set.
  LOST: match -> ACQUIRE with mcnt=1; mismatch stays.
REQ-010 period_valid SHALL pulse on every detect cycle in ACQUIRE, LOCKED and LOST, coincident with the half_period update.
REQ-011 If hcnt reaches saturation in a state other than IDLE: timeout pulses one cycle, state -> IDLE, mcnt=0; err is set if the state was LOCKED. hcnt SHALL hold saturated until the next edge.
REQ-012 clr_err=1 SHALL clear err next cycle; a simultaneous new error event wins (err stays 1).
REQ-013 en=0 SHALL hold state IDLE and keep hcnt, mcnt and toggle_count at 0, with no pulses; the synchronizer keeps running. A rising en SHALL NOT generate an edge from stale history.
REQ-014 An edge on the saturation cycle SHALL be processed as an edge; timeout SHALL NOT assert.

Reset
REQ-015 When reset is asserted, all flops SHALL clear immediately: s1/s2/s3=0, hcnt=0, mcnt=0, half_period=0, toggle_count=0, state=IDLE, all pulses/locked/err=0.
REQ-016 Reset mid-measurement SHALL discard any partial interval; the first edge after release -> ACQUIRE without period_valid.

Verification
REQ-017 Toggle every 5 clk, exp_half=5, TOL=1 -> state IDLE->ACQUIRE->LOCKED after edge 3; half_period=5; locked=1; err=0.
REQ-018 While locked, a single 9-clk half-period -> state LOST, err=1; following 5-clk halves -> ACQUIRE then LOCKED; err stays 1 until clr_err pulse.
REQ-019 CNT_W=4, locked, toggle stops -> timeout pulse after hcnt reaches 15, state IDLE, err=1; toggle_count holds its value.
REQ-020 Half-periods 4, 6, 7 with exp_half=5, TOL=1 -> match, match (LOCKED), mismatch (LOST); half_period shows 4, 6, 7.
REQ-021 Assert reset mid-interval and during a LOCKED run -> all outputs are 0 the same cycle; the first post-reset edge gives ACQUIRE with no period_valid.
REQ-022 clr_err and a LOCKED mismatch in the same cycle -> err=1.
